// File: rtl/uart_rx_deserializer_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for port hookup.
// master: the receiver itself; slave: the line driver / byte consumer.
interface uart_rx_deserializer_if;
  logic       rxIN;
  logic [7:0] dataOUT;
  logic       validOUT;
  logic       frameErrorOUT;
  logic       parityErrorOUT;
  logic       busyOUT;

  modport master (
    input  rxIN,
    output dataOUT,
    output validOUT,
    output frameErrorOUT,
    output parityErrorOUT,
    output busyOUT
  );

  modport slave (
    output rxIN,
    input  dataOUT,
    input  validOUT,
    input  frameErrorOUT,
    input  parityErrorOUT,
    input  busyOUT
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 / 8E1 UART receiver with mid-bit sampling, single holding register and break recovery.
// Define RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                          clockIN,
  input  logic                          resetIN,
  uart_rx_deserializer_if.master        bus
);

  localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned HalfBit = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
`ifdef RX_PARITY_EN
    Parity,
`endif
    Stop,
    Break
  } state_t;

  state_t          state;
  logic [CntW-1:0] cycleCount;
  logic [2:0]      bitCount;
  logic [7:0]      shiftReg;
  logic [7:0]      dataReg;
  logic            validReg;
  logic            frameErrReg;
  logic            busyReg;
`ifdef RX_PARITY_EN
  logic            parityBad;
  logic            parityErrReg;
`endif

  // Frame sequencer; the cycle counter restarts at every sample point so no drift accumulates.
  always_ff @(posedge clockIN or posedge resetIN) begin
    if (resetIN) begin
      state        <= Idle;
      cycleCount   <= '0;
      bitCount     <= '0;
      shiftReg     <= '0;
      dataReg      <= '0;
      validReg     <= 1'b0;
      frameErrReg  <= 1'b0;
      busyReg      <= 1'b0;
`ifdef RX_PARITY_EN
      parityBad    <= 1'b0;
      parityErrReg <= 1'b0;
`endif
    end else begin
      validReg     <= 1'b0;
      frameErrReg  <= 1'b0;
`ifdef RX_PARITY_EN
      parityErrReg <= 1'b0;
`endif
      case (state)
        Idle: begin
          if (!bus.rxIN) begin
            state      <= Start;
            cycleCount <= '0;
            busyReg    <= 1'b1;
          end
        end

        Start: begin
          if (cycleCount == HalfLast) begin
            cycleCount <= '0;
            if (bus.rxIN) begin
              // Start bit did not survive to its midpoint: treat as a glitch.
              state   <= Idle;
              busyReg <= 1'b0;
            end else begin
              state    <= Data;
              bitCount <= '0;
            end
          end else begin
            cycleCount <= cycleCount + CntW'(1);
          end
        end

        Data: begin
          if (cycleCount == BitLast) begin
            cycleCount <= '0;
            shiftReg   <= {bus.rxIN, shiftReg[7:1]};
            bitCount   <= bitCount + 3'd1;
            if (bitCount == 3'd7) begin
`ifdef RX_PARITY_EN
              state <= Parity;
`else
              state <= Stop;
`endif
            end
          end else begin
            cycleCount <= cycleCount + CntW'(1);
          end
        end

`ifdef RX_PARITY_EN
        Parity: begin
          if (cycleCount == BitLast) begin
            cycleCount <= '0;
            parityBad  <= bus.rxIN != (^shiftReg);
            state      <= Stop;
          end else begin
            cycleCount <= cycleCount + CntW'(1);
          end
        end
`endif

        Stop: begin
          if (cycleCount == BitLast) begin
            cycleCount <= '0;
            if (bus.rxIN) begin
              // Leave at the stop midpoint so an immediately following start bit is caught.
              state   <= Idle;
              busyReg <= 1'b0;
`ifdef RX_PARITY_EN
              if (parityBad) begin
                parityErrReg <= 1'b1;
              end else begin
                validReg <= 1'b1;
                dataReg  <= shiftReg;
              end
`else
              validReg <= 1'b1;
              dataReg  <= shiftReg;
`endif
            end else begin
              frameErrReg <= 1'b1;
              state       <= Break;
            end
          end else begin
            cycleCount <= cycleCount + CntW'(1);
          end
        end

        Break: begin
          if (bus.rxIN) begin
            state   <= Idle;
            busyReg <= 1'b0;
          end
        end

        default: begin
          state   <= Idle;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOUT       = dataReg;
  assign bus.validOUT      = validReg;
  assign bus.frameErrorOUT = frameErrReg;
  assign bus.busyOUT       = busyReg;
`ifdef RX_PARITY_EN
  assign bus.parityErrorOUT = parityErrReg;
`else
  assign bus.parityErrorOUT = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer at 16 clocks per bit.
// Frames push their expected strobe; a negedge monitor pops and compares when any strobe fires.
module tb_uart_rx_deserializer;

  localparam int C = 16;
  localparam int H = C / 2;

  localparam int KindValid  = 0;
  localparam int KindFrame  = 1;
  localparam int KindParity = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         atEdge;
    logic       busy;
  } exp_t;

  logic clockIN = 1'b0;
  logic resetIN;
  uart_rx_deserializer_if bus();

  uart_rx_deserializer #(.CLKS_PER_BIT(C)) dut (
    .clockIN (clockIN),
    .resetIN (resetIN),
    .bus     (bus.master)
  );

  always #5 clockIN = ~clockIN;

  int   edgeCount = 0;
  int   checks    = 0;
  int   errors    = 0;
  exp_t expQ[$];
  logic [7:0] modelData = 8'h00;
  int   lastValidEdge = 0;
  int   prevValidEdge = 0;

  always @(posedge clockIN) edgeCount <= edgeCount + 1;

  task automatic checkValue(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edgeCount);
    end
  endtask

  // Pops one expectation for every strobe the receiver produces.
  always @(negedge clockIN) begin
    int   kindObs;
    exp_t e;
    if (bus.validOUT || bus.frameErrorOUT || bus.parityErrorOUT) begin
      checkValue("strobe onehot",
                 int'(bus.validOUT) + int'(bus.frameErrorOUT) + int'(bus.parityErrorOUT), 1);
      kindObs = bus.validOUT ? KindValid : (bus.frameErrorOUT ? KindFrame : KindParity);
      if (bus.validOUT) begin
        prevValidEdge = lastValidEdge;
        lastValidEdge = edgeCount;
      end
      if (expQ.size() == 0) begin
        checkValue("unexpected strobe kind", kindObs, -1);
      end else begin
        e = expQ.pop_front();
        checkValue("strobe kind", kindObs, e.kind);
        checkValue("strobe edge", edgeCount, e.atEdge);
        checkValue("strobe data", int'(bus.dataOUT), int'(e.data));
        checkValue("strobe busy", int'(bus.busyOUT), int'(e.busy));
      end
    end
  end

  // Drives one frame bit-by-bit starting just after a negedge; abortAt >= 0 pulses reset at that cycle.
  task automatic sendFrame(input logic [7:0] value, input logic stopBit, input logic parityBit,
                           input int kind, input int abortAt);
    logic [10:0] bits;
    int   nBits;
    int   e0;
    exp_t e;
`ifdef RX_PARITY_EN
    bits  = {stopBit, parityBit, value, 1'b0};
    nBits = 11;
`else
    bits  = {parityBit, stopBit, value, 1'b0};
    nBits = 10;
`endif
    e0 = edgeCount + 1;
    if (abortAt < 0) begin
      e.kind   = kind;
      e.data   = (kind == KindValid) ? value : modelData;
      e.atEdge = e0 + H + (nBits - 1) * C;
      e.busy   = (kind == KindFrame);
      if (kind == KindValid) modelData = value;
      expQ.push_back(e);
    end
    for (int c = 0; c < nBits * C; c++) begin
      if (c == abortAt) begin
        resetIN   = 1'b1;
        bus.rxIN  = 1'b1;
        modelData = 8'h00;
        #1;
        checkValue("abort dataOUT", int'(bus.dataOUT), 0);
        checkValue("abort busyOUT", int'(bus.busyOUT), 0);
        checkValue("abort strobes",
                   int'({bus.validOUT, bus.frameErrorOUT, bus.parityErrorOUT}), 0);
        @(negedge clockIN);
        @(negedge clockIN);
        resetIN = 1'b0;
        return;
      end
      bus.rxIN = bits[c / C];
      @(negedge clockIN);
    end
  endtask

  task automatic idle(input int n);
    bus.rxIN = 1'b1;
    repeat (n) @(negedge clockIN);
  endtask

  initial begin
    resetIN  = 1'b1;
    bus.rxIN = 1'b1;
    repeat (3) @(negedge clockIN);
    checkValue("reset dataOUT", int'(bus.dataOUT), 0);
    checkValue("reset busyOUT", int'(bus.busyOUT), 0);
    checkValue("reset strobes", int'({bus.validOUT, bus.frameErrorOUT, bus.parityErrorOUT}), 0);
    resetIN = 1'b0;
    idle(5);

    // Plain byte.
    sendFrame(8'hA5, 1'b1, ^8'hA5, KindValid, -1);
    idle(10);

    // Start glitch: low for 4 cycles, busy for cycles 1..8 only.
    bus.rxIN = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clockIN);
      if (i == 3) bus.rxIN = 1'b1;
      checkValue("glitch busyOUT", int'(bus.busyOUT), (i < H) ? 1 : 0);
    end
    idle(10);

    // Stop bit low, line held low: one frame error, busy until release.
    sendFrame(8'h3C, 1'b0, ^8'h3C, KindFrame, -1);
    bus.rxIN = 1'b0;
    repeat (300 - C) @(negedge clockIN);
    checkValue("break busyOUT", int'(bus.busyOUT), 1);
    bus.rxIN = 1'b1;
    @(negedge clockIN);
    checkValue("break release busyOUT", int'(bus.busyOUT), 0);
    idle(5);
    sendFrame(8'h55, 1'b1, ^8'h55, KindValid, -1);
    idle(10);

    // Back-to-back frames, second start bit right after the first stop bit.
    sendFrame(8'h00, 1'b1, ^8'h00, KindValid, -1);
    sendFrame(8'hFF, 1'b1, ^8'hFF, KindValid, -1);
    idle(10);
    checkValue("b2b spacing", lastValidEdge - prevValidEdge, C * (10 +
`ifdef RX_PARITY_EN
      1
`else
      0
`endif
      ));

    // Reset mid-frame, then a clean frame.
    sendFrame(8'h81, 1'b1, ^8'h81, KindValid, 70);
    idle(2 * C);
    checkValue("post-abort dataOUT", int'(bus.dataOUT), 0);
    sendFrame(8'h81, 1'b1, ^8'h81, KindValid, -1);
    idle(10);

`ifdef RX_PARITY_EN
    sendFrame(8'h07, 1'b1, 1'b1, KindValid, -1);
    idle(10);
    sendFrame(8'h07, 1'b1, 1'b0, KindParity, -1);
    idle(10);
`endif

    idle(20);
    checkValue("scoreboard drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Asynchronous serial (8N1 / 8E1) receiver that consumes the majority-filtered RX line and produces parallel bytes with a one-cycle valid strobe. Sits directly downstream of the RX majority filter and upstream of the command/pixel-data parser that loads the WS2811 frame buffer. Start-bit detection, mid-bit sampling, stop-bit validation and break recovery are all handled here. Bytes are never buffered beyond a single holding register.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 4.
- clockIN  input  1  system clock; all logic on its rising edge
- resetIN  input  1  asynchronous, active-high reset
- rxIN  input  1  filtered serial line; idle high; LSB first
- dataOUT  output  8  last received byte; updated only together with validOUT
- validOUT  output  1  one-cycle strobe: dataOUT holds a new good byte
- frameErrorOUT  output  1  one-cycle strobe: stop bit sampled low
- parityErrorOUT  output  1  one-cycle strobe: parity mismatch (see Configuration)
- busyOUT  output  1  high in every state except IDLE

## Operation
- Reset values: state IDLE, dataOUT 0x00, validOUT/frameErrorOUT/parityErrorOUT/busyOUT 0, bit counter 0, cycle counter 0.
- States:
  - IDLE: rxIN==0 → START, clear cycle counter.
  - START: count to H-1, where H = CLKS_PER_BIT/2 (floor), then sample rxIN. 0 → DATA. 1 → IDLE (glitch, no strobe).
  - DATA: each CLKS_PER_BIT cycles, shift the sampled rxIN into bit 7 of the shift register (LSB first). After the 8th sample → PARITY if enabled, else STOP.
  - PARITY: after CLKS_PER_BIT cycles, sample rxIN and compare to even parity of the 8 data bits.
  - STOP: after CLKS_PER_BIT cycles, sample rxIN.
    - 1: load dataOUT with the shift register. Pulse validOUT, unless a parity error was latched, in which case pulse parityErrorOUT instead and leave dataOUT unchanged. → IDLE.
    - 0: pulse frameErrorOUT; dataOUT unchanged → BREAK.
  - BREAK: stay until rxIN==1 → IDLE. Line-held-low (break) produces exactly one frameErrorOUT.
- At most one of validOUT, frameErrorOUT, parityErrorOUT is high in any cycle.
- A frame error takes precedence over a parity error; only frameErrorOUT pulses.
- Cycle counter width $clog2(CLKS_PER_BIT). It resets to 0 on every sample point, with no accumulated drift.
- Return to IDLE at the stop-bit midpoint, so a start bit immediately after the stop bit is detected.
- resetIN mid-frame aborts the frame immediately: no strobe, outputs at reset values.

## Timing
- C = CLKS_PER_BIT, H = C/2. Cycle 0 is the first clockIN edge at which IDLE sees rxIN==0.
- Sample points:
  - start: cycle H
  - data bit n (0..7): cycle H+(n+1)·C
  - parity: cycle H+9C
  - stop: cycle H+9C (no parity) or H+10C (parity)
- Strobe outputs are registered and are high for the single cycle after the stop sample:
  - H+9C+1 (no parity)
  - H+10C+1 (parity)
- busyOUT rises at cycle 1 and falls in the cycle the strobe rises. In BREAK, busyOUT stays high until rxIN returns high.
- Tolerates ±4 % baud mismatch by construction of mid-bit sampling.
- No backpressure: the consumer must accept validOUT when it is asserted. Minimum byte spacing is H+9C+1 cycles.

## Configuration
- RX_PARITY_EN defined: PARITY state present; an even-parity bit is expected between data and stop; parityErrorOUT functional.
- RX_PARITY_EN undefined: PARITY state removed; DATA goes directly to STOP; parityErrorOUT tied 0.

## Test plan
Bench uses C=16 (H=8), no parity unless stated.
- 0xA5 framed 8N1 from cycle 0 → validOUT high only at cycle 153, dataOUT=0xA5, busyOUT low at 153, no error strobes.
- rxIN low for 4 cycles then high → no strobe, busyOUT high for cycles 1..8, then IDLE.
- 0x3C with stop bit low, line held low for 300 cycles → one frameErrorOUT at cycle 153, dataOUT keeps its previous value, busyOUT high until rxIN rises, then a following 0x55 frame → validOUT, dataOUT=0x55.
- Back-to-back 0x00 then 0xFF, with the second start bit immediately after the first stop bit → two validOUT pulses exactly 160 cycles apart, values 0x00, 0xFF.
- resetIN pulsed at cycle 70 of a 0x81 frame → all outputs 0 at once. No strobe for the aborted frame. A clean 0x81 frame sent after reset deassert and line idle → validOUT, dataOUT=0x81.
- RX_PARITY_EN:
  - 0x07 with parity bit 1 → validOUT at cycle 169.
  - Same frame with parity bit 0 → parityErrorOUT at cycle 169, no validOUT, dataOUT unchanged.
